// File: rtl/led_cube_pkg.sv
// Shared constants and loader state encoding for the LED cube UART frame path.
// TX_ECHO_EN adds the echo states to the loader FSM.
package led_cube_pkg;

  localparam logic [4:0] UART_RXDATA = 5'd0;
  localparam logic [4:0] UART_TXDATA = 5'd1;
  localparam logic [4:0] UART_STATUS = 5'd2;

  localparam int STAT_RRDY = 7;
  localparam int STAT_TRDY = 6;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    POLL_ST,
    WAIT_ST,
    RD_RX,
    WAIT_RX,
    PROC
`ifdef TX_ECHO_EN
    ,
    ECHO_ST,
    ECHO_WAIT,
    ECHO_WR
`endif
  } loader_state_t;

endpackage

// File: rtl/led_frame_dbuf.sv
// Double-buffered frame store: writes go to the back buffer, the driver reads the front.
// front_sel picks which physical array is the front; read data is registered.
module led_frame_dbuf #(
  parameter int FRAME_BYTES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [5:0] waddr,
  input  logic [7:0] wdata,
  input  logic       front_sel,
  input  logic       loaded,
  input  logic [5:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] buf0 [FRAME_BYTES];
  logic [7:0] buf1 [FRAME_BYTES];

  // NOTE: the arrays have no reset so they map onto plain RAM; rd_data masks them until a frame lands.
  always_ff @(posedge clk) begin
    if (we) begin
      if (front_sel) buf0[waddr] <= wdata;
      else           buf1[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= 8'h00;
    end else if (!loaded || ({1'b0, rd_addr} >= 7'(FRAME_BYTES))) begin
      rd_data <= 8'h00;
    end else begin
      rd_data <= front_sel ? buf1[rd_addr] : buf0[rd_addr];
    end
  end

endmodule

// File: rtl/uart_frame_loader.sv
// Avalon-MM master that polls a UART and assembles sync-prefixed frames into led_frame_dbuf.
// Define TX_ECHO_EN to write every received byte back to TXDATA once TRDY is set.
module uart_frame_loader
  import led_cube_pkg::*;
#(
  parameter int         FRAME_BYTES    = 64,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [4:0]  avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [15:0] avm_writedata,
  input  logic [15:0] avm_readdata,
  input  logic        avm_readdatavalid,
  input  logic        avm_waitrequest,
  input  logic [5:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic        frame_valid,
  output logic [7:0]  frame_count,
  output logic        err_timeout
);

  localparam int              TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [5:0]      LAST_IDX = 6'(FRAME_BYTES - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  loader_state_t   state, state_nxt;
  logic            run;
  logic            hunting;
  logic            front_sel;
  logic            loaded;
  logic            buf_we;
  logic [5:0]      byte_idx;
  logic [7:0]      rx_byte;
  logic [TO_W-1:0] idle_cnt;
  logic            unused_rdata;

  assign unused_rdata = ^{avm_readdata[15:8], avm_readdata[STAT_TRDY]};
  assign buf_we       = (state == PROC) && !hunting;

  // NOTE: every output and state_nxt gets a default first so no path through the case infers a latch.
  always_comb begin
    state_nxt     = state;
    avm_read      = 1'b0;
    avm_write     = 1'b0;
    avm_address   = 5'd0;
    avm_writedata = 16'h0000;
    case (state)
      POLL_ST: begin
        // run holds the strobes low until the first clock after reset release
        if (run) begin
          avm_read    = 1'b1;
          avm_address = UART_STATUS;
          if (!avm_waitrequest) state_nxt = WAIT_ST;
        end
      end
      WAIT_ST: if (avm_readdatavalid) state_nxt = avm_readdata[STAT_RRDY] ? RD_RX : POLL_ST;
      RD_RX: begin
        avm_read    = 1'b1;
        avm_address = UART_RXDATA;
        if (!avm_waitrequest) state_nxt = WAIT_RX;
      end
      WAIT_RX: if (avm_readdatavalid) state_nxt = PROC;
`ifdef TX_ECHO_EN
      PROC: state_nxt = ECHO_ST;
      ECHO_ST: begin
        avm_read    = 1'b1;
        avm_address = UART_STATUS;
        if (!avm_waitrequest) state_nxt = ECHO_WAIT;
      end
      ECHO_WAIT: if (avm_readdatavalid) state_nxt = avm_readdata[STAT_TRDY] ? ECHO_WR : ECHO_ST;
      ECHO_WR: begin
        avm_write     = 1'b1;
        avm_address   = UART_TXDATA;
        avm_writedata = {8'h00, rx_byte};
        if (!avm_waitrequest) state_nxt = POLL_ST;
      end
`else
      PROC: state_nxt = POLL_ST;
`endif
      default: state_nxt = POLL_ST;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= POLL_ST;
      run         <= 1'b0;
      hunting     <= 1'b1;
      byte_idx    <= 6'd0;
      front_sel   <= 1'b0;
      loaded      <= 1'b0;
      rx_byte     <= 8'h00;
      idle_cnt    <= '0;
      frame_valid <= 1'b0;
      frame_count <= 8'd0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      run         <= 1'b1;
      frame_valid <= 1'b0;
      if (state == WAIT_RX && avm_readdatavalid) rx_byte <= avm_readdata[7:0];
      if (state == PROC) begin
        // a byte arriving on the timeout cycle wins: the counter simply restarts
        idle_cnt <= '0;
        if (hunting) begin
          if (rx_byte == SYNC_BYTE) begin
            hunting  <= 1'b0;
            byte_idx <= 6'd0;
          end
        end else if (byte_idx == LAST_IDX) begin
          front_sel   <= ~front_sel;
          frame_valid <= 1'b1;
          frame_count <= frame_count + 8'd1;
          loaded      <= 1'b1;
          hunting     <= 1'b1;
          byte_idx    <= 6'd0;
        end else begin
          byte_idx <= byte_idx + 6'd1;
        end
      end else if (!hunting) begin
        if (idle_cnt == TO_LAST) begin
          idle_cnt    <= '0;
          err_timeout <= 1'b1;
          hunting     <= 1'b1;
          byte_idx    <= 6'd0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end
  end

  led_frame_dbuf #(.FRAME_BYTES(FRAME_BYTES)) u_dbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (buf_we),
    .waddr     (byte_idx),
    .wdata     (rx_byte),
    .front_sel (front_sel),
    .loaded    (loaded),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

endmodule

// File: tb/tb_uart_frame_loader.sv
// Self-checking bench for uart_frame_loader: behavioural UART slave, byte-stream frame model,
// table-driven front-buffer reads and hand-written corner sequences (echo checks under TX_ECHO_EN).
module tb_uart_frame_loader;
  import led_cube_pkg::*;

  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  avm_address;
  logic        avm_read, avm_write;
  logic [15:0] avm_writedata, avm_readdata;
  logic        avm_readdatavalid, avm_waitrequest;
  logic [5:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        frame_valid;
  logic [7:0]  frame_count;
  logic        err_timeout;

  always #5 clk = ~clk;

  uart_frame_loader #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_waitrequest   (avm_waitrequest),
    .rd_addr           (rd_addr),
    .rd_data           (rd_data),
    .frame_valid       (frame_valid),
    .frame_count       (frame_count),
    .err_timeout       (err_timeout)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural UART slave ----------------
  logic [7:0]  rxq[$];
  int          nr_req = 0, nr_done = 0;          // forced RRDY=0 answers
  int          stall_req = 0, stall_used = 0, stall_len = 0;
  int          echo_req = 0, echo_done = 0, trdy_wait = 0;
  bit          random_stall = 0;
  int          status_reads = 0, rx_reads = 0, wr_count = 0, status_at_rx = 0;
  int          stall_seen = 0, proto_err = 0, hold_err = 0, underflow = 0, fv_pulses = 0;
  int          status_base_echo = 0, status_at_wr = 0;
  logic [15:0] last_wdata = 16'h0;
  logic [4:0]  last_waddr = 5'h0;
  bit          pending = 0, in_stall = 0;
  int          stall_left = 0;
  logic [15:0] pend_data = 16'h0;
  logic [4:0]  held_addr = 5'h0;
  logic        held_rd = 1'b0, held_wr = 1'b0, rrdy, trdy;

  initial begin
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = 16'h0;
    forever begin
      @(negedge clk);
      avm_readdatavalid = 1'b0;
      avm_readdata      = 16'($urandom);
      if (pending) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = pend_data;
        pending           = 0;
      end
      if (frame_valid) fv_pulses++;
      if (avm_read && avm_write) proto_err++;
      if (!rst_n) begin
        avm_waitrequest = 1'b0;
        in_stall        = 0;
      end else if (avm_read || avm_write) begin
        if (!in_stall) begin
          stall_left = 0;
          if (random_stall) stall_left = $urandom_range(0, 2);
          else if (stall_used != stall_req) begin
            stall_left = stall_len;
            stall_used = stall_req;
          end
          in_stall = 1; held_addr = avm_address; held_rd = avm_read; held_wr = avm_write;
        end else if (avm_address !== held_addr || avm_read !== held_rd || avm_write !== held_wr) begin
          hold_err++;
        end
        if (stall_left > 0) begin
          avm_waitrequest = 1'b1;
          stall_left--;
          stall_seen++;
        end else begin
          avm_waitrequest = 1'b0;
          in_stall        = 0;
          if (avm_read) begin
            pending = 1;
            if (avm_address == UART_STATUS) begin
              status_reads++;
              rrdy = (rxq.size() > 0) && (nr_done == nr_req);
              if (rxq.size() > 0 && nr_done != nr_req) nr_done++;
              trdy = (trdy_wait == 0);
              if (trdy_wait > 0) trdy_wait--;
              pend_data = {8'h00, rrdy, trdy, 6'h00};
            end else if (avm_address == UART_RXDATA) begin
              rx_reads++;
              status_at_rx = status_reads;
              if (rxq.size() > 0) pend_data = {8'h00, rxq.pop_front()};
              else begin underflow++; pend_data = 16'h0; end
              if (echo_done != echo_req) begin
                echo_done        = echo_req;
                trdy_wait        = 2;
                status_base_echo = status_reads;
              end
            end else begin
              proto_err++;
              pend_data = 16'h0;
            end
          end else begin
            wr_count++;
            last_wdata   = avm_writedata;
            last_waddr   = avm_address;
            status_at_wr = status_reads - status_base_echo;
          end
        end
      end else begin
        if (in_stall) hold_err++;
        avm_waitrequest = 1'b0;
        in_stall        = 0;
      end
    end
  end

  // ---------------- frame model: sync hunt, payload collection, timeout abort ----------------
  bit         m_hunting = 1, m_loaded = 0, m_err = 0;
  int         m_idx = 0, m_count = 0;
  logic [7:0] m_pay[64], m_front[64];
  logic [7:0] fr[64];

  task automatic feed(input logic [7:0] b);
    rxq.push_back(b);
    if (m_hunting) begin
      if (b == 8'hA5) begin m_hunting = 0; m_idx = 0; end
    end else begin
      m_pay[m_idx] = b;
      m_idx++;
      if (m_idx == 64) begin
        m_front   = m_pay;
        m_count   = (m_count + 1) % 256;
        m_loaded  = 1;
        m_hunting = 1;
      end
    end
  endtask

  task automatic model_gap();
    if (!m_hunting) begin m_err = 1; m_hunting = 1; end
  endtask

  task automatic push_fr();
    feed(8'hA5);
    for (int i = 0; i < 64; i++) feed(fr[i]);
  endtask

  task automatic sync_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (rxq.size() != 0 && t < 4000) begin sync_cycle(); t++; end
    check("drain_budget", 32'(t < 4000), 32'd1);
    repeat (16) sync_cycle();
  endtask

  task automatic read_front(input logic [5:0] a, output logic [7:0] d);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    d = rd_data;
  endtask

  typedef struct {
    logic [5:0] addr;
    logic [7:0] exp;
  } rd_vec_t;

  rd_vec_t    tbl[6];
  logic [7:0] d;
  int         s_st, s_rx, s_stall, s_fv, s_wr, t;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{addr: 6'd0,  exp: 8'h00};
    tbl[1] = '{addr: 6'd5,  exp: 8'h05};
    tbl[2] = '{addr: 6'd31, exp: 8'h1F};
    tbl[3] = '{addr: 6'd42, exp: 8'h2A};
    tbl[4] = '{addr: 6'd62, exp: 8'h3E};
    tbl[5] = '{addr: 6'd63, exp: 8'h3F};
    rd_addr = 6'd0;
    rst_n   = 1'b0;
    #2;
    check("rst_read",    32'(avm_read),      32'd0);
    check("rst_write",   32'(avm_write),     32'd0);
    check("rst_address", 32'(avm_address),   32'd0);
    check("rst_wdata",   32'(avm_writedata), 32'd0);
    check("rst_fvalid",  32'(frame_valid),   32'd0);
    check("rst_fcount",  32'(frame_count),   32'd0);
    check("rst_err",     32'(err_timeout),   32'd0);
    check("rst_rd_data", 32'(rd_data),       32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      read_front(tbl[i].addr, d);
      check("unloaded_rd", 32'(d), 32'd0);
    end

    // three not-ready polls, then 0x3C which hunt mode discards
    sync_cycle();
    s_st = status_reads; s_rx = rx_reads;
    nr_req = nr_req + 3;
    feed(8'h3C);
    drain();
    check("t1_status_reads", 32'(status_at_rx - s_st), 32'd4);
    check("t1_rx_reads",     32'(rx_reads - s_rx),     32'd1);
    check("t1_fcount",       32'(frame_count),         32'd0);

    // one read stalled by waitrequest for 4 cycles
    sync_cycle();
    s_st = status_reads; s_rx = rx_reads; s_stall = stall_seen;
    stall_len = 4;
    stall_req++;
    feed(8'h11);
    drain();
    check("t3_stall_cycles", 32'(stall_seen - s_stall), 32'd4);
    check("t3_status_reads", 32'(status_at_rx - s_st),  32'd1);
    check("t3_rx_reads",     32'(rx_reads - s_rx),      32'd1);
    check("t3_hold",         32'(hold_err),             32'd0);

    // first full frame 00..3F
    for (int i = 0; i < 64; i++) fr[i] = 8'(i);
    push_fr();
    drain();
    check("t2_pulses", 32'(fv_pulses),   32'd1);
    check("t2_fcount", 32'(frame_count), 32'd1);
    check("t2_err",    32'(err_timeout), 32'd0);
    for (int i = 0; i < 6; i++) begin
      read_front(tbl[i].addr, d);
      check("t2_rd", {18'd0, tbl[i].addr, d}, {18'd0, tbl[i].addr, tbl[i].exp});
    end

    // randomised byte stream against the model
    random_stall = 1;
    for (int r = 0; r < 12; r++) begin
      int kind, n;
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        for (int i = 0; i < 64; i++) fr[i] = 8'($urandom);
        push_fr();
      end else if (kind == 1) begin
        n = $urandom_range(1, 4);
        for (int i = 0; i < n; i++) feed(8'($urandom));
      end else begin
        feed(8'hA5);
        n = $urandom_range(1, 20);
        for (int i = 0; i < n; i++) feed(8'($urandom));
        drain();
        repeat (TMO + 60) sync_cycle();
        model_gap();
      end
      drain();
      check("rnd_fcount", 32'(frame_count), 32'(m_count));
      check("rnd_err",    32'(err_timeout), 32'(m_err));
      check("rnd_pulses", 32'(fv_pulses),   32'(m_count));
      for (int k = 0; k < 2; k++) begin
        logic [5:0] a;
        a = 6'($urandom);
        read_front(a, d);
        check("rnd_rd", {18'd0, a, d}, {18'd0, a, (m_loaded ? m_front[a] : 8'h00)});
      end
    end
    random_stall = 0;

    // reset while the RXDATA response is outstanding
    s_rx = rx_reads;
    feed(8'h77);
    t = 0;
    while (rx_reads == s_rx && t < 200) begin sync_cycle(); t++; end
    check("rst_wait_rx_budget", 32'(t < 200), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_read",   32'(avm_read),    32'd0);
    check("mid_rst_addr",   32'(avm_address), 32'd0);
    check("mid_rst_fcount", 32'(frame_count), 32'd0);
    check("mid_rst_err",    32'(err_timeout), 32'd0);
    check("mid_rst_fvalid", 32'(frame_valid), 32'd0);
    @(negedge clk);
    check("mid_rst_rd_data", 32'(rd_data), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    m_hunting = 1; m_loaded = 0; m_err = 0; m_count = 0;
    s_fv = fv_pulses;
    for (int i = 0; i < 64; i++) fr[i] = 8'(i + 8'h80);
    push_fr();
    drain();
    check("post_rst_fcount", 32'(frame_count),      32'd1);
    check("post_rst_pulses", 32'(fv_pulses - s_fv), 32'd1);
    read_front(6'd0, d);  check("post_rst_rd0",  32'(d), 32'h80);
    read_front(6'd63, d); check("post_rst_rd63", 32'(d), 32'hBF);

    // partial frame then silence: timeout, front untouched
    feed(8'hA5);
    for (int i = 0; i < 10; i++) feed(8'(8'hE0 + i));
    drain();
    check("t4_err_early", 32'(err_timeout), 32'd0);
    repeat (TMO + 60) sync_cycle();
    check("t4_err",    32'(err_timeout),      32'd1);
    check("t4_pulses", 32'(fv_pulses - s_fv), 32'd1);
    check("t4_fcount", 32'(frame_count),      32'd1);
    read_front(6'd9, d);  check("t4_front9",  32'(d), 32'h89);
    read_front(6'd0, d);  check("t4_front0",  32'(d), 32'h80);
    for (int i = 0; i < 64; i++) fr[i] = 8'(i * 3);
    push_fr();
    drain();
    check("t4_reload_fcount", 32'(frame_count), 32'd2);
    check("t4_err_sticky",    32'(err_timeout), 32'd1);
    read_front(6'd9, d);  check("t4_reload9",  32'(d), 32'h1B);
    read_front(6'd63, d); check("t4_reload63", 32'(d), 32'hBD);

    // two back-to-back frames, the second all 0xFF
    s_fv = fv_pulses;
    for (int i = 0; i < 64; i++) fr[i] = 8'(i) ^ 8'h55;
    push_fr();
    for (int i = 0; i < 64; i++) fr[i] = 8'hFF;
    push_fr();
    drain();
    check("t5_pulses", 32'(fv_pulses - s_fv), 32'd2);
    check("t5_fcount", 32'(frame_count),      32'd4);
    read_front(6'd0, d);  check("t5_rd0",  32'(d), 32'hFF);
    read_front(6'd20, d); check("t5_rd20", 32'(d), 32'hFF);
    read_front(6'd63, d); check("t5_rd63", 32'(d), 32'hFF);

`ifdef TX_ECHO_EN
    sync_cycle();
    s_wr = wr_count;
    echo_req++;
    feed(8'h5A);
    drain();
    check("echo_writes",       32'(wr_count - s_wr), 32'd1);
    check("echo_addr",         32'(last_waddr),      32'd1);
    check("echo_data",         32'(last_wdata),      32'h005A);
    check("echo_trdy_polls",   32'(status_at_wr),    32'd3);
`endif

    check("protocol_rw_overlap", 32'(proto_err), 32'd0);
    check("hold_stable",         32'(hold_err),  32'd0);
    check("rx_underflow",        32'(underflow), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
